// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter sharing one slave port between the CPU path and the DMA engine.
// Round-robin per transaction, with master abort handling and a slave-timeout watchdog.
module wb_mem_arbiter #(
    parameter int pADDR_WIDTH = 32,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 64
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n_i,
    input  logic                   cpu_stb_i,
    input  logic                   cpu_cyc_i,
    input  logic                   cpu_we_i,
    input  logic [3:0]             cpu_sel_i,
    input  logic [pADDR_WIDTH-1:0] cpu_adr_i,
    input  logic [pDATA_WIDTH-1:0] cpu_dat_i,
    output logic                   cpu_ack_o,
    output logic                   cpu_err_o,
    output logic [pDATA_WIDTH-1:0] cpu_dat_o,
    input  logic                   dma_stb_i,
    input  logic                   dma_cyc_i,
    input  logic                   dma_we_i,
    input  logic [3:0]             dma_sel_i,
    input  logic [pADDR_WIDTH-1:0] dma_adr_i,
    input  logic [pDATA_WIDTH-1:0] dma_dat_i,
    output logic                   dma_ack_o,
    output logic                   dma_err_o,
    output logic [pDATA_WIDTH-1:0] dma_dat_o,
    output logic                   mem_stb_o,
    output logic                   mem_cyc_o,
    output logic                   mem_we_o,
    output logic [3:0]             mem_sel_o,
    output logic [pADDR_WIDTH-1:0] mem_adr_o,
    output logic [pDATA_WIDTH-1:0] mem_dat_o,
    input  logic                   mem_ack_i,
    input  logic [pDATA_WIDTH-1:0] mem_dat_i,
    output logic [1:0]             gnt_o
);

    localparam int TW = $clog2(pTIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(pTIMEOUT - 1);

    // State encoding doubles as the one-hot grant vector
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CPU  = 2'b01;
    localparam logic [1:0] ST_DMA  = 2'b10;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          last_dma_r;
    logic [TW-1:0] timer_r;
    logic          req_cpu_s;
    logic          req_dma_s;
    logic          own_cyc_s;
    logic          expire_s;

    assign req_cpu_s = cpu_stb_i & cpu_cyc_i;
    assign req_dma_s = dma_stb_i & dma_cyc_i;
    assign own_cyc_s = ((state_r == ST_CPU) & cpu_cyc_i) | ((state_r == ST_DMA) & dma_cyc_i);
    assign expire_s  = (timer_r == TMAX);

    // State register, round-robin history and watchdog timer
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r    <= ST_IDLE;
            last_dma_r <= 1'b1;
            timer_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r != ST_IDLE) && (state_nxt_s == state_r)) begin
                timer_r <= timer_r + TW'(1);
            end else begin
                timer_r <= '0;
            end
            if ((state_r == ST_IDLE) && (state_nxt_s != ST_IDLE)) begin
                last_dma_r <= (state_nxt_s == ST_DMA);
            end else begin
                last_dma_r <= last_dma_r;
            end
        end
    end

    // Next-state: every transaction ends in IDLE so each one re-arbitrates
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_cpu_s && req_dma_s) begin
                    state_nxt_s = last_dma_r ? ST_CPU : ST_DMA;
                end else if (req_cpu_s) begin
                    state_nxt_s = ST_CPU;
                end else if (req_dma_s) begin
                    state_nxt_s = ST_DMA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CPU, ST_DMA: begin
                if (mem_ack_i || !own_cyc_s || expire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output mux: slave port follows the granted master, ack/err routed back only to it
    always_comb begin
        mem_stb_o = 1'b0;
        mem_cyc_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_sel_o = 4'b0000;
        mem_adr_o = '0;
        mem_dat_o = '0;
        cpu_ack_o = 1'b0;
        cpu_err_o = 1'b0;
        dma_ack_o = 1'b0;
        dma_err_o = 1'b0;
        cpu_dat_o = mem_dat_i;
        dma_dat_o = mem_dat_i;
        gnt_o     = state_r;
        case (state_r)
            ST_CPU: begin
                mem_stb_o = cpu_stb_i;
                mem_cyc_o = cpu_cyc_i;
                mem_we_o  = cpu_we_i;
                mem_sel_o = cpu_sel_i;
                mem_adr_o = cpu_adr_i;
                mem_dat_o = cpu_dat_i;
                cpu_ack_o = mem_ack_i;
                cpu_err_o = expire_s & ~mem_ack_i & cpu_cyc_i;
            end
            ST_DMA: begin
                mem_stb_o = dma_stb_i;
                mem_cyc_o = dma_cyc_i;
                mem_we_o  = dma_we_i;
                mem_sel_o = dma_sel_i;
                mem_adr_o = dma_adr_i;
                mem_dat_o = dma_dat_i;
                dma_ack_o = mem_ack_i;
                dma_err_o = expire_s & ~mem_ack_i & dma_cyc_i;
            end
            default: begin
                mem_stb_o = 1'b0;
            end
        endcase
    end

endmodule
